// File: rtl/arilla_bus_pkg.sv
// Shared bus widths, responder state encoding and window decode helper.
// Combinational only; no latency, no backpressure.
package arilla_bus_pkg;

    localparam int ARILLA_ADDR_W = 32;
    localparam int ARILLA_DATA_W = 32;
    localparam int ARILLA_BE_W   = 4;

    typedef logic [1:0] resp_state_t;

    localparam resp_state_t RESP_IDLE = 2'd0;
    localparam resp_state_t RESP_WAIT = 2'd1;
    localparam resp_state_t RESP_DONE = 2'd2;

    // size must be a power of two and base aligned to it
    function automatic logic window_match(
        input logic [ARILLA_ADDR_W-1:0] addr,
        input logic [ARILLA_ADDR_W-1:0] base,
        input logic [ARILLA_ADDR_W-1:0] size
    );
        return (addr & ~(size - 32'd1)) == base;
    endfunction

endpackage

// File: rtl/arilla_bus_if.sv
// Simple request/complete memory bus between initiator and responders.
// Initiator holds a request stable until it samples complete.
interface arilla_bus_if;
    import arilla_bus_pkg::*;

    logic [ARILLA_ADDR_W-1:0] address;
    logic                     read;
    logic                     write;
    logic [ARILLA_DATA_W-1:0] write_data;
    logic [ARILLA_BE_W-1:0]   byte_enable;
    logic [ARILLA_DATA_W-1:0] read_data;
    logic                     complete;

    modport responder (
        input  address, read, write, write_data, byte_enable,
        output read_data, complete
    );

    modport initiator (
        output address, read, write, write_data, byte_enable,
        input  read_data, complete
    );

endinterface

// File: rtl/sp_ram_be.sv
// Single-port RAM with per-byte write enables; read data one cycle after en.
// No backpressure: every enabled access is performed at the clock edge.
module sp_ram_be #(
    parameter int    Width    = 32,
    parameter int    Depth    = 1024,
    parameter string InitFile = ""
) (
    input  logic                                  clk,
    input  logic                                  en,
    input  logic                                  we,
    input  logic [Width/8-1:0]                    be,
    input  logic [((Depth > 1) ? $clog2(Depth) : 1)-1:0] addr,
    input  logic [Width-1:0]                      wdata,
    output logic [Width-1:0]                      rdata
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < Width / 8; i++) begin
                    if (be[i]) begin
                        mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/arilla_mem_responder.sv
// Windowed byte-writable memory responder; complete pulses Latency+1 cycles after acceptance.
// No backpressure: the initiator holds its request until complete, unselected requests are ignored.
module arilla_mem_responder
    import arilla_bus_pkg::*;
#(
    parameter logic [31:0] BaseAddress = 32'h0000_0000,
    parameter int          Size        = 4096,
    parameter int          Latency     = 0,
    parameter string       InitFile    = ""
) (
    input  logic                   clk,
    input  logic                   rst_n,
    arilla_bus_if.responder        bus_interface
);

    localparam int          Depth = Size / 4;
    localparam int          IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [31:0] SizeW = 32'(Size);
    localparam logic [3:0]  LatM1 = (Latency > 0) ? 4'(Latency - 1) : 4'd0;

    resp_state_t              state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     wr_q, wr_d;
    logic                     rd_q, rd_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [ARILLA_DATA_W-1:0] wdata_q, wdata_d;
    logic [ARILLA_BE_W-1:0]   be_q, be_d;

    logic                     sel;
    logic [IdxW-1:0]          req_idx;
    logic                     enter_done;
    logic                     ram_en;
    logic                     ram_we;
    logic [ARILLA_DATA_W-1:0] ram_rdata;

    assign sel = (bus_interface.read | bus_interface.write) &&
                 window_match(bus_interface.address, BaseAddress, SizeW);

    // offset within the window, so the index can never leave the RAM
    assign req_idx = IdxW'((bus_interface.address & (SizeW - 32'd1)) >> 2);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        enter_done = 1'b0;

        case (state_q)
            RESP_IDLE: begin
                if (sel) begin
                    wr_d    = bus_interface.write;
                    rd_d    = bus_interface.read & ~bus_interface.write;
                    idx_d   = req_idx;
                    wdata_d = bus_interface.write_data;
                    be_d    = bus_interface.byte_enable;
                    if (Latency > 0) begin
                        state_d = RESP_WAIT;
                        cnt_d   = LatM1;
                    end else begin
                        state_d    = RESP_DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            RESP_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP_DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP_DONE: begin
                state_d = RESP_IDLE;
            end
            default: begin
                state_d = RESP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RESP_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // The _d values carry the live bus fields at Latency=0 and the latched ones otherwise.
    assign ram_en = enter_done & (wr_d | rd_d) & rst_n;
    assign ram_we = wr_d;

    sp_ram_be #(
        .Width    (ARILLA_DATA_W),
        .Depth    (Depth),
        .InitFile (InitFile)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (be_d),
        .addr  (idx_d),
        .wdata (wdata_d),
        .rdata (ram_rdata)
    );

    assign bus_interface.complete  = (state_q == RESP_DONE);
    assign bus_interface.read_data = ((state_q == RESP_DONE) && rd_q) ? ram_rdata : '0;

endmodule
